// File: rtl/conway_pkg.sv
// Shared definitions for the Conway board: default geometry, command opcodes,
// UART key codes and the command-decoder state type.
package conway_pkg;

    localparam int DEF_LOG_WIDTH  = 3;
    localparam int DEF_LOG_HEIGHT = 3;

    localparam logic [2:0] OP_NONE        = 3'd0;
    localparam logic [2:0] OP_RANDOMIZE   = 3'd1;
    localparam logic [2:0] OP_STEP        = 3'd2;
    localparam logic [2:0] OP_RUN_TOGGLE  = 3'd3;
    localparam logic [2:0] OP_TOGGLE_CELL = 3'd4;
    localparam logic [2:0] OP_CLEAR       = 3'd5;
    localparam logic [2:0] OP_CURSOR      = 3'd6;

    localparam logic [7:0] KEY_RANDOMIZE  = 8'h30;
    localparam logic [7:0] KEY_STEP       = 8'h31;
    localparam logic [7:0] KEY_RUN        = 8'h20;
    localparam logic [7:0] KEY_TOGGLE_LO  = 8'h78;
    localparam logic [7:0] KEY_TOGGLE_UP  = 8'h58;
    localparam logic [7:0] KEY_CLEAR      = 8'h63;
    localparam logic [7:0] KEY_ESC        = 8'h1B;
    localparam logic [7:0] KEY_CSI        = 8'h5B;
    localparam logic [7:0] KEY_UP         = 8'h41;
    localparam logic [7:0] KEY_DOWN       = 8'h42;
    localparam logic [7:0] KEY_RIGHT      = 8'h43;
    localparam logic [7:0] KEY_LEFT       = 8'h44;

    typedef enum logic [1:0] {
        IDLE,
        ESC,
        CSI,
        HOLD
    } dec_state_t;

    // Single-byte commands; OP_NONE means the byte is not a plain command key.
    function automatic logic [2:0] key_to_op(input logic [7:0] key);
        case (key)
            KEY_RANDOMIZE:                key_to_op = OP_RANDOMIZE;
            KEY_STEP:                     key_to_op = OP_STEP;
            KEY_RUN:                      key_to_op = OP_RUN_TOGGLE;
            KEY_TOGGLE_LO, KEY_TOGGLE_UP: key_to_op = OP_TOGGLE_CELL;
            KEY_CLEAR:                    key_to_op = OP_CLEAR;
            default:                      key_to_op = OP_NONE;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Turns UART key bytes (plain keys and ESC [ arrow sequences) into single
// board commands, keeping the cursor position and a count of discarded bytes.
module uart_cmd_decoder
    import conway_pkg::*;
#(
    parameter int LOG_WIDTH   = DEF_LOG_WIDTH,
    parameter int LOG_HEIGHT  = DEF_LOG_HEIGHT,
    parameter int ESC_TIMEOUT = 24000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            cmd_valid,
    output logic [2:0]                      cmd_op,
    output logic [LOG_WIDTH+LOG_HEIGHT-1:0] cmd_cell,
    input  logic                            cmd_ready,
    output logic [LOG_WIDTH-1:0]            cursor_x,
    output logic [LOG_HEIGHT-1:0]           cursor_y,
    output logic [7:0]                      unknown_count
);

    localparam int              TW         = $clog2(ESC_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    // Handshakes: a byte moves when rx_valid && rx_ready, a command moves when
    // cmd_valid && cmd_ready, both on the rising clk edge; neither side may
    // make its valid depend combinationally on the other side's ready.
    dec_state_t             state;
    logic [TW-1:0]          esc_timer;
    logic                   accept;
    logic [2:0]             single_op;
    logic                   arrow_hit;
    logic [LOG_WIDTH-1:0]   next_x;
    logic [LOG_HEIGHT-1:0]  next_y;

    assign rx_ready  = (state != HOLD);
    assign accept    = rx_valid && rx_ready;
    assign single_op = key_to_op(rx_data);

    // Wrapping falls out of the natural modulo of the cursor register widths.
    always_comb begin
        arrow_hit = 1'b1;
        next_x    = cursor_x;
        next_y    = cursor_y;
        case (rx_data)
            KEY_UP:    next_y = cursor_y - LOG_HEIGHT'(1);
            KEY_DOWN:  next_y = cursor_y + LOG_HEIGHT'(1);
            KEY_RIGHT: next_x = cursor_x + LOG_WIDTH'(1);
            KEY_LEFT:  next_x = cursor_x - LOG_WIDTH'(1);
            default:   arrow_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cmd_valid     <= 1'b0;
            cmd_op        <= OP_NONE;
            cmd_cell      <= '0;
            cursor_x      <= '0;
            cursor_y      <= '0;
            unknown_count <= '0;
            esc_timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    esc_timer <= '0;
                    if (accept) begin
                        if (single_op != OP_NONE) begin
                            cmd_valid <= 1'b1;
                            cmd_op    <= single_op;
                            cmd_cell  <= {cursor_y, cursor_x};
                            state     <= HOLD;
                        end else if (rx_data == KEY_ESC) begin
                            state <= ESC;
                        end else begin
                            unknown_count <= sat_inc8(unknown_count);
                        end
                    end
                end
                ESC, CSI: begin
                    // An accepted byte wins over a timer expiring in the same cycle.
                    if (accept) begin
                        esc_timer <= '0;
                        if (state == ESC) begin
                            if (rx_data == KEY_CSI) begin
                                state <= CSI;
                            end else if (rx_data != KEY_ESC) begin
                                unknown_count <= sat_inc8(unknown_count);
                                state         <= IDLE;
                            end
                        end else if (arrow_hit) begin
                            cursor_x  <= next_x;
                            cursor_y  <= next_y;
                            cmd_valid <= 1'b1;
                            cmd_op    <= OP_CURSOR;
                            cmd_cell  <= {next_y, next_x};
                            state     <= HOLD;
                        end else begin
                            unknown_count <= sat_inc8(unknown_count);
                            state         <= IDLE;
                        end
                    end else if (esc_timer == TIMER_LAST) begin
                        esc_timer <= '0;
                        state     <= IDLE;
                    end else begin
                        esc_timer <= esc_timer + TW'(1);
                    end
                end
                HOLD: begin
                    esc_timer <= '0;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed vectors and sequences plus
// random traffic compared against a key-sequence reference model.
module tb_uart_cmd_decoder;

    localparam int TO = 40;
    localparam int W  = 8;
    localparam int H  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [5:0] cmd_cell;
    logic       cmd_ready = 1'b1;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic [7:0] unknown_count;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    int valid_cycles = 0;
    int dut_xfers = 0;

    // Reference model: cursor, discard count, partial escape bytes, idle gap.
    int         m_x = 0, m_y = 0, m_unk = 0, m_gap = 0;
    logic       m_pending = 1'b0;
    logic [7:0] m_seq[$];
    logic [8:0] exp_q[$];

    logic [7:0] key_pool[14];

    typedef struct {
        logic [7:0] b;
        logic       exp_v;
        logic [2:0] exp_op;
    } vec_t;
    vec_t vecs[9];

    uart_cmd_decoder #(
        .LOG_WIDTH(3),
        .LOG_HEIGHT(3),
        .ESC_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_cell(cmd_cell),
        .cmd_ready(cmd_ready),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .unknown_count(unknown_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model helpers
    task automatic m_reset();
        m_x = 0; m_y = 0; m_unk = 0; m_gap = 0;
        m_pending = 1'b0;
        m_seq.delete();
        exp_q.delete();
    endtask

    task automatic m_bump();
        if (m_unk < 255) m_unk++;
    endtask

    task automatic m_emit(input int op);
        logic [2:0] o;
        logic [5:0] c;
        o = 3'(op);
        c = 6'(m_y * W + m_x);
        exp_q.push_back({o, c});
        m_pending = 1'b1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        m_gap = 0;
        if (m_seq.size() == 0) begin
            case (b)
                8'h30: m_emit(1);
                8'h31: m_emit(2);
                8'h20: m_emit(3);
                8'h78, 8'h58: m_emit(4);
                8'h63: m_emit(5);
                8'h1B: m_seq.push_back(b);
                default: m_bump();
            endcase
        end else if (m_seq.size() == 1) begin
            if (b == 8'h5B) m_seq.push_back(b);
            else if (b != 8'h1B) begin
                m_seq.delete();
                m_bump();
            end
        end else begin
            m_seq.delete();
            if (b >= 8'h41 && b <= 8'h44) begin
                if (b == 8'h41) m_y = (m_y + H - 1) % H;
                if (b == 8'h42) m_y = (m_y + 1) % H;
                if (b == 8'h43) m_x = (m_x + 1) % W;
                if (b == 8'h44) m_x = (m_x + W - 1) % W;
                m_emit(6);
            end else begin
                m_bump();
            end
        end
    endtask

    // Scoreboard: compare current outputs, then advance the model by this edge.
    always @(negedge clk) begin
        logic acc;
        if (chk_en) begin
            check("rx_ready", rx_ready, !m_pending);
            check("cmd_valid", cmd_valid, m_pending);
            check("cursor_x", cursor_x, m_x);
            check("cursor_y", cursor_y, m_y);
            check("unknown_count", unknown_count, m_unk);
            if (m_pending) begin
                check("cmd_op", cmd_op, exp_q[0][8:6]);
                check("cmd_cell", cmd_cell, exp_q[0][5:0]);
            end
        end
        if (cmd_valid === 1'b1) valid_cycles++;
        if (cmd_valid === 1'b1 && cmd_ready) dut_xfers++;
        if (reset) begin
            m_reset();
        end else begin
            acc = rx_valid && !m_pending;
            if (cmd_ready && m_pending) begin
                m_pending = 1'b0;
                void'(exp_q.pop_front());
            end
            if (acc) m_byte(rx_data);
            else if (m_seq.size() != 0) begin
                m_gap++;
                if (m_gap >= TO) m_seq.delete();
            end
        end
    end

    // Driver tasks: all drives happen just after a rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sync();
        sync();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ready && n < 200);
        check("rx_ready_wait", rx_ready, 1'b1);
        sync();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 9) < 9) return key_pool[$urandom_range(0, 13)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int x0, v0;
        key_pool = '{8'h30, 8'h31, 8'h20, 8'h78, 8'h58, 8'h63, 8'h1B,
                     8'h1B, 8'h5B, 8'h5B, 8'h41, 8'h42, 8'h43, 8'h44};
        vecs[0] = '{8'h30, 1'b1, 3'd1};
        vecs[1] = '{8'h31, 1'b1, 3'd2};
        vecs[2] = '{8'h20, 1'b1, 3'd3};
        vecs[3] = '{8'h78, 1'b1, 3'd4};
        vecs[4] = '{8'h58, 1'b1, 3'd4};
        vecs[5] = '{8'h63, 1'b1, 3'd5};
        vecs[6] = '{8'h7A, 1'b0, 3'd0};
        vecs[7] = '{8'h41, 1'b0, 3'd0};
        vecs[8] = '{8'h5B, 1'b0, 3'd0};

        repeat (3) sync();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and rx_ready on the first cycle out of reset
        @(negedge clk);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_op", cmd_op, 3'd0);
        check("rst_cmd_cell", cmd_cell, 6'd0);
        check("rst_cursor", {cursor_y, cursor_x}, 6'd0);
        check("rst_unknown", unknown_count, 8'd0);
        sync();

        // '1' with cmd_ready high: one-cycle command pulse
        cmd_ready = 1'b1;
        send_byte(8'h31);
        @(negedge clk);
        check("step_valid", cmd_valid, 1'b1);
        check("step_op", cmd_op, 3'd2);
        @(negedge clk);
        check("step_valid_drop", cmd_valid, 1'b0);
        sync();

        // Single-byte vector table from IDLE
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].b);
            @(negedge clk);
            check("vec_valid", cmd_valid, vecs[i].exp_v);
            if (vecs[i].exp_v) check("vec_op", cmd_op, vecs[i].exp_op);
            sync();
        end
        check("vec_unknown", unknown_count, 8'd3);

        // Arrow keys with wrap
        do_reset();
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h44);
        @(negedge clk);
        check("left_x", cursor_x, 3'd7);
        check("left_y", cursor_y, 3'd0);
        check("left_op", cmd_op, 3'd6);
        check("left_cell", cmd_cell, 6'd7);
        sync();
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h41);
        @(negedge clk);
        check("up_y", cursor_y, 3'd7);
        check("up_cell", cmd_cell, 6'd63);
        sync();

        // Back-pressure: command held for 10 cycles, then one transfer
        cmd_ready = 1'b0;
        send_byte(8'h78);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rx_ready", rx_ready, 1'b0);
            check("hold_valid", cmd_valid, 1'b1);
            check("hold_op", cmd_op, 3'd4);
            check("hold_cell", cmd_cell, 6'd63);
        end
        sync();
        x0 = dut_xfers;
        cmd_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", cmd_valid, 1'b1);
        @(negedge clk);
        check("hold_release_drop", cmd_valid, 1'b0);
        check("hold_xfers", dut_xfers - x0, 1);
        sync();

        // Escape timeout, and acceptance on the last timer cycle
        do_reset();
        send_byte(8'h1B);
        repeat (TO) sync();
        send_byte(8'h31);
        @(negedge clk);
        check("to_op", cmd_op, 3'd2);
        check("to_valid", cmd_valid, 1'b1);
        check("to_cursor", {cursor_y, cursor_x}, 6'd0);
        check("to_unknown", unknown_count, 8'd0);
        sync();
        send_byte(8'h1B);
        repeat (TO - 1) sync();
        send_byte(8'h5B);
        send_byte(8'h43);
        @(negedge clk);
        check("edge_op", cmd_op, 3'd6);
        check("edge_x", cursor_x, 3'd1);
        check("edge_unknown", unknown_count, 8'd0);
        sync();
        send_byte(8'h1B);
        repeat (TO) sync();
        send_byte(8'h5B);
        @(negedge clk);
        check("late_csi_unknown", unknown_count, 8'd1);
        check("late_csi_valid", cmd_valid, 1'b0);
        sync();

        // Discard counter saturation
        do_reset();
        v0 = valid_cycles;
        for (int i = 0; i < 300; i++) send_byte(8'h7A);
        @(negedge clk);
        check("sat_unknown", unknown_count, 8'd255);
        check("sat_no_valid", valid_cycles - v0, 0);
        sync();

        // Reset during HOLD
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h43);
        sync();
        cmd_ready = 1'b0;
        send_byte(8'h63);
        @(negedge clk);
        check("mid_hold_valid", cmd_valid, 1'b1);
        sync();
        reset = 1'b1;
        sync();
        @(negedge clk);
        check("mid_rst_valid", cmd_valid, 1'b0);
        check("mid_rst_cursor", {cursor_y, cursor_x}, 6'd0);
        sync();
        reset = 1'b0;
        cmd_ready = 1'b1;
        sync();

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(TO - 2, TO + 2)) sync();
            end
            rx_valid  = ($urandom_range(0, 9) < 7);
            rx_data   = rand_byte();
            cmd_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 999) == 0) reset = 1'b1;
            else reset = 1'b0;
            sync();
        end
        rx_valid = 1'b0;
        reset = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) sync();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
